// File: rtl/serial_magnitude_comparator.sv
// rtl/serial_magnitude_comparator.sv - digit-serial magnitude comparator with valid/ready handshakes
module serial_magnitude_comparator #(
    parameter int WIDTH      = 32,
    parameter int DIGIT      = 4,
    parameter int EARLY_EXIT = 1
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [WIDTH-1:0]                   a,
    input  logic [WIDTH-1:0]                   b,
    input  logic                               signed_mode,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic                               g,
    output logic                               e,
    output logic                               s,
    output logic [$clog2(WIDTH/DIGIT+1)-1:0]   cycles
);
    localparam int NDIG = WIDTH / DIGIT;
    localparam int IW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t            state, state_n;
    logic [WIDTH-1:0]  a_r, b_r;
    logic [IW-1:0]     idx;
    logic [CW-1:0]     cnt;
    logic              diff, gt;
    logic [DIGIT-1:0]  da, db;
    logic              differ, stop, diff_n, gt_n;

    // Signed compare is done by flipping the sign bits at capture; only the top digit changes.
    assign da     = a_r[idx*DIGIT +: DIGIT];
    assign db     = b_r[idx*DIGIT +: DIGIT];
    assign differ = (da != db);
    assign stop   = ((EARLY_EXIT != 0) && differ) || (idx == '0);
    assign diff_n = diff | differ;
    assign gt_n   = diff ? gt : (da > db);
    assign in_ready = (state == IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (in_valid) state_n = RUN;
            RUN:     if (stop) state_n = DONE;
            DONE:    if (out_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Operand capture, digit walk, first-difference latch and registered results.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r       <= '0;
            b_r       <= '0;
            idx       <= '0;
            cnt       <= '0;
            diff      <= 1'b0;
            gt        <= 1'b0;
            out_valid <= 1'b0;
            g         <= 1'b0;
            e         <= 1'b0;
            s         <= 1'b0;
            cycles    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_r  <= a ^ (signed_mode ? MSB : '0);
                        b_r  <= b ^ (signed_mode ? MSB : '0);
                        idx  <= IW'(NDIG - 1);
                        cnt  <= '0;
                        diff <= 1'b0;
                        gt   <= 1'b0;
                    end
                end
                RUN: begin
                    cnt  <= cnt + CW'(1);
                    diff <= diff_n;
                    gt   <= gt_n;
                    if (stop) begin
                        out_valid <= 1'b1;
                        g         <= diff_n & gt_n;
                        s         <= diff_n & ~gt_n;
                        e         <= ~diff_n;
                        cycles    <= cnt + CW'(1);
                    end else begin
                        idx <= idx - IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        g         <= 1'b0;
                        e         <= 1'b0;
                        s         <= 1'b0;
                        cycles    <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_magnitude_comparator.sv
// tb/tb_serial_magnitude_comparator.sv - self-checking bench for serial_magnitude_comparator
module tb_serial_magnitude_comparator;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] av = '0, bv = '0;
    logic        smv = 1'b0, iv = 1'b0, ordy = 1'b0;
    int          sel = 0;
    int          nchk = 0, nerr = 0;

    int wd[3] = '{8, 8, 32};
    int dg[3] = '{2, 2, 4};
    int ex[3] = '{1, 0, 1};

    logic       rdy0, rdy1, rdy2, ov0, ov1, ov2;
    logic       g0, g1, g2, e0, e1, e2, s0, s1, s2;
    logic [2:0] cyc0, cyc1;
    logic [3:0] cyc2;

    logic       cur_rdy, cur_ov, cur_g, cur_e, cur_s;
    int         cur_cyc;

    logic exp_g, exp_e, exp_s;
    int   exp_k;

    always #5 clk = ~clk;

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 0), .in_ready(rdy0),
        .a(av[7:0]), .b(bv[7:0]), .signed_mode(smv), .out_valid(ov0),
        .out_ready(ordy && sel == 0), .g(g0), .e(e0), .s(s0), .cycles(cyc0));

    serial_magnitude_comparator #(.WIDTH(8), .DIGIT(2), .EARLY_EXIT(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 1), .in_ready(rdy1),
        .a(av[7:0]), .b(bv[7:0]), .signed_mode(smv), .out_valid(ov1),
        .out_ready(ordy && sel == 1), .g(g1), .e(e1), .s(s1), .cycles(cyc1));

    serial_magnitude_comparator #(.WIDTH(32), .DIGIT(4), .EARLY_EXIT(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv && sel == 2), .in_ready(rdy2),
        .a(av), .b(bv), .signed_mode(smv), .out_valid(ov2),
        .out_ready(ordy && sel == 2), .g(g2), .e(e2), .s(s2), .cycles(cyc2));

    always_comb begin
        cur_rdy = rdy0; cur_ov = ov0; cur_g = g0; cur_e = e0; cur_s = s0; cur_cyc = int'(cyc0);
        if (sel == 1) begin
            cur_rdy = rdy1; cur_ov = ov1; cur_g = g1; cur_e = e1; cur_s = s1; cur_cyc = int'(cyc1);
        end else if (sel == 2) begin
            cur_rdy = rdy2; cur_ov = ov2; cur_g = g2; cur_e = e2; cur_s = s2; cur_cyc = int'(cyc2);
        end
    end

    task automatic chk(input string name, input longint act, input longint expv);
        nchk++;
        if (act != expv) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Reference: relation from whole-number arithmetic, latency from the first differing digit.
    task automatic model(input logic [31:0] ma, input logic [31:0] mb, input logic msm,
                         input int w, input int d, input int ee,
                         output logic og, output logic oe, output logic os, output int ok);
        longint va, vb, mask;
        int nd;
        va = longint'(ma);
        vb = longint'(mb);
        if (msm && ma[w-1]) va = va - (longint'(1) << w);
        if (msm && mb[w-1]) vb = vb - (longint'(1) << w);
        og = (va > vb);
        oe = (va == vb);
        os = (va < vb);
        nd = w / d;
        ok = nd;
        mask = (longint'(1) << d) - 1;
        if (ee != 0) begin
            for (int i = 0; i < nd; i++) begin
                int sh;
                sh = (nd - 1 - i) * d;
                if (((longint'(ma) >> sh) & mask) != ((longint'(mb) >> sh) & mask)) begin
                    ok = i + 1;
                    break;
                end
            end
        end
    endtask

    // Whenever a result is presented it must match the model and be one-hot.
    always @(negedge clk) begin
        if (rst_n && cur_ov) begin
            chk("g", longint'(cur_g), longint'(exp_g));
            chk("e", longint'(cur_e), longint'(exp_e));
            chk("s", longint'(cur_s), longint'(exp_s));
            chk("cycles", longint'(cur_cyc), longint'(exp_k));
            chk("onehot", longint'(cur_g) + longint'(cur_e) + longint'(cur_s), 1);
            chk("in_ready_busy", longint'(cur_rdy), 0);
        end
    end

    task automatic run_cmp(input int d, input logic [31:0] ta, input logic [31:0] tb_v,
                           input logic tsm, input int stall);
        int n;
        logic mg, me, ms;
        int mk;
        sel = d;
        model(ta, tb_v, tsm, wd[d], dg[d], ex[d], mg, me, ms, mk);
        exp_g = mg; exp_e = me; exp_s = ms; exp_k = mk;
        n = 0;
        @(negedge clk);
        while (!cur_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("in_ready_idle", longint'(cur_rdy), 1);
        av = ta; bv = tb_v; smv = tsm; iv = 1'b1;
        @(posedge clk);
        #1;
        iv = 1'b0; av = $urandom; bv = $urandom; smv = 1'($urandom);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!cur_ov && n < 100);
        chk("latency", longint'(n - 1), longint'(mk));
        for (int i = 0; i < stall; i++) begin
            iv = 1'b1; av = 32'hFFFF_FFFF; bv = 32'h0;
            @(negedge clk);
            chk("stall_in_ready", longint'(cur_rdy), 0);
            chk("stall_out_valid", longint'(cur_ov), 1);
        end
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0; iv = 1'b0;
        @(negedge clk);
        chk("out_valid_drop", longint'(cur_ov), 0);
        chk("in_ready_after", longint'(cur_rdy), 1);
    endtask

    initial begin
        logic mg, me, ms;
        int mk;
        logic [31:0] ra, rb;

        model(32'hA5, 32'hA5, 1'b0, 8, 2, 1, mg, me, ms, mk);
        chk("model_eq", {me, mk[7:0]}, {1'b1, 8'd4});
        model(32'h80, 32'h7F, 1'b1, 8, 2, 1, mg, me, ms, mk);
        chk("model_signed", {ms, mk[7:0]}, {1'b1, 8'd1});
        model(32'hFF, 32'hFE, 1'b1, 8, 2, 1, mg, me, ms, mk);
        chk("model_signed2", {mg, mk[7:0]}, {1'b1, 8'd4});
        model(32'h40, 32'h00, 1'b0, 8, 2, 0, mg, me, ms, mk);
        chk("model_const", {mg, mk[7:0]}, {1'b1, 8'd4});

        #1;
        chk("reset_in_ready", longint'(cur_rdy), 1);
        chk("reset_out_valid", longint'(cur_ov), 0);
        chk("reset_ges", {cur_g, cur_e, cur_s}, 0);
        chk("reset_cycles", longint'(cur_cyc), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_cmp(0, 32'hA5, 32'hA5, 1'b0, 0);
        run_cmp(0, 32'h80, 32'h7F, 1'b0, 0);
        run_cmp(0, 32'h80, 32'h7F, 1'b1, 0);
        run_cmp(0, 32'hFF, 32'hFE, 1'b1, 0);
        run_cmp(1, 32'h40, 32'h00, 1'b0, 0);
        run_cmp(0, 32'h12, 32'h34, 1'b0, 5);
        run_cmp(0, 32'hFF, 32'h00, 1'b0, 0);

        // Abort during the third RUN cycle of a wide compare.
        sel = 2;
        @(negedge clk);
        av = 32'd0; bv = 32'd1; smv = 1'b0; iv = 1'b1;
        @(posedge clk);
        #1 iv = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", longint'(cur_ov), 0);
        chk("abort_in_ready", longint'(cur_rdy), 1);
        chk("abort_ges", {cur_g, cur_e, cur_s}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_cmp(2, 32'd5, 32'd5, 1'b0, 0);

        for (int i = 0; i < 90; i++) begin
            int d;
            d = i % 3;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = ra;
                1:       rb = ra ^ (32'h1 << $urandom_range(0, wd[d] - 1));
                default: rb = $urandom;
            endcase
            if (wd[d] == 8) begin
                ra = ra & 32'hFF;
                rb = rb & 32'hFF;
            end
            run_cmp(d, ra, rb, 1'($urandom), $urandom_range(0, 3));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
